// File: rtl/riscv32ima_amo_ctrl.sv
// RV32A atomic sequencer: runs LR.W / SC.W / AMO*.W read-modify-write on the
// 64-bit data port, holds the LR/SC reservation and returns rd data.
module riscv32ima_amo_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [4:0]                req_func5,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [REG_DATA_WIDTH-1:0] req_data,
    input  logic [REG_ADDR_WIDTH-1:0] req_dst_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [REG_ADDR_WIDTH-1:0] rsp_reg_addr,
    output logic [REG_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_err,
    input  logic                      snp_valid,
    input  logic [ADDR_WIDTH-1:0]     snp_addr,
    output logic                      d_ncs,
    output logic                      d_nwe,
    output logic [ADDR_WIDTH-1:0]     d_addr,
    output logic [DATA_WIDTH-1:0]     d_wdata,
    output logic [DATA_WIDTH-1:0]     d_wmask,
    input  logic [DATA_WIDTH-1:0]     d_rdata,
    input  logic                      d_stall
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RDW  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    logic [2:0]                r_state;
    logic [4:0]                r_func5;
    logic [ADDR_WIDTH-1:2]     r_addr;
    logic [REG_DATA_WIDTH-1:0] r_data;
    logic [REG_DATA_WIDTH-1:0] r_result;
    logic [REG_ADDR_WIDTH-1:0] r_dst;
    logic                      r_resv_valid;
    logic [ADDR_WIDTH-1:2]     r_resv_addr;

    logic                      r_req_ready;
    logic                      r_rsp_valid;
    logic                      r_rsp_err;
    logic [REG_ADDR_WIDTH-1:0] r_rsp_reg_addr;
    logic [REG_DATA_WIDTH-1:0] r_rsp_data;
    logic                      r_d_ncs;
    logic                      r_d_nwe;
    logic [ADDR_WIDTH-1:0]     r_d_addr;
    logic [DATA_WIDTH-1:0]     r_d_wdata;
    logic [DATA_WIDTH-1:0]     r_d_wmask;

    logic [2:0]                w_state_next;
    logic                      w_accept;
    logic                      w_misaligned;
    logic                      w_resv_hit;
    logic                      w_snp_hit;
    logic [REG_DATA_WIDTH-1:0] w_old;
    logic [REG_DATA_WIDTH-1:0] w_new;
    logic [REG_DATA_WIDTH-1:0] w_wr_word;
    logic                      w_wr_hi;
    logic [REG_DATA_WIDTH-1:0] w_rsp_data;
    logic                      w_rsp_err;
    logic [REG_ADDR_WIDTH-1:0] w_rsp_dst;
    logic                      w_resv_valid_next;
    logic [ADDR_WIDTH-1:2]     w_resv_addr_next;

    assign w_accept     = req_valid & r_req_ready;
    assign w_misaligned = (req_addr[1:0] != 2'b00);
    assign w_resv_hit   = r_resv_valid && (req_addr[ADDR_WIDTH-1:2] == r_resv_addr);
    assign w_old        = r_addr[2] ? d_rdata[DATA_WIDTH-1:REG_DATA_WIDTH]
                                    : d_rdata[REG_DATA_WIDTH-1:0];
    assign w_wr_word    = (r_state == S_IDLE) ? req_data : w_new;
    assign w_wr_hi      = (r_state == S_IDLE) ? req_addr[2] : r_addr[2];

    // AMO combine; unknown funct5 codes (and LR/SC) fall through to SWAP
    always_comb begin
        w_new = r_data;
        case (r_func5)
            F_ADD:   w_new = w_old + r_data;
            F_XOR:   w_new = w_old ^ r_data;
            F_OR:    w_new = w_old | r_data;
            F_AND:   w_new = w_old & r_data;
            F_MIN:   w_new = ($signed(w_old) < $signed(r_data)) ? w_old : r_data;
            F_MAX:   w_new = ($signed(w_old) > $signed(r_data)) ? w_old : r_data;
            F_MINU:  w_new = (w_old < r_data) ? w_old : r_data;
            F_MAXU:  w_new = (w_old > r_data) ? w_old : r_data;
            default: w_new = r_data;
        endcase
    end

    // next state, response payload and reservation update
    always_comb begin
        w_state_next      = r_state;
        w_rsp_data        = '0;
        w_rsp_err         = 1'b0;
        w_rsp_dst         = r_dst;
        w_resv_valid_next = r_resv_valid;
        w_resv_addr_next  = r_resv_addr;
        case (r_state)
            S_IDLE: begin
                w_rsp_dst = req_dst_addr;
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_state_next = S_RSP;
                        w_rsp_err    = 1'b1;
                    end else if (req_func5 == F_SC) begin
                        w_resv_valid_next = 1'b0;
                        if (w_resv_hit) begin
                            w_state_next = S_WR;
                        end else begin
                            w_state_next = S_RSP;
                            w_rsp_data   = REG_DATA_WIDTH'(1);
                        end
                    end else begin
                        w_state_next = S_RD;
                    end
                end
            end
            S_RD: if (d_stall) w_state_next = S_RDW;
            S_RDW: begin
                if (r_func5 == F_LR) begin
                    w_state_next      = S_RSP;
                    w_rsp_data        = w_old;
                    w_resv_valid_next = 1'b1;
                    w_resv_addr_next  = r_addr;
                end else begin
                    w_state_next = S_WR;
                end
            end
            S_WR: begin
                w_rsp_data = r_result;
                if (d_stall) w_state_next = S_RSP;
            end
            S_RSP: if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // a snoop hitting the (possibly just-set) reservation always wins
        if (snp_valid && w_snp_hit) w_resv_valid_next = 1'b0;
    end

    assign w_snp_hit = ((snp_addr ^ {w_resv_addr_next, 2'b00}) >> 2) == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_func5        <= '0;
            r_addr         <= '0;
            r_data         <= '0;
            r_result       <= '0;
            r_dst          <= '0;
            r_resv_valid   <= 1'b0;
            r_resv_addr    <= '0;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_reg_addr <= '0;
            r_rsp_data     <= '0;
            r_d_ncs        <= 1'b1;
            r_d_nwe        <= 1'b1;
            r_d_addr       <= '0;
            r_d_wdata      <= '0;
            r_d_wmask      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_resv_valid <= w_resv_valid_next;
            r_resv_addr  <= w_resv_addr_next;
            r_req_ready  <= (w_state_next == S_IDLE);
            r_rsp_valid  <= (w_state_next == S_RSP);
            r_d_ncs      <= !((w_state_next == S_RD) || (w_state_next == S_WR));
            r_d_nwe      <= (w_state_next != S_WR);
            if (w_accept) begin
                r_func5  <= req_func5;
                r_addr   <= req_addr[ADDR_WIDTH-1:2];
                r_data   <= req_data;
                r_dst    <= req_dst_addr;
                r_result <= '0;
                r_d_addr <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
            end
            if (r_state == S_RDW) r_result <= w_old;
            if ((w_state_next == S_WR) && (r_state != S_WR)) begin
                r_d_wdata <= {w_wr_word, w_wr_word};
                r_d_wmask <= w_wr_hi ? {{REG_DATA_WIDTH{1'b0}}, {REG_DATA_WIDTH{1'b1}}}
                                     : {{REG_DATA_WIDTH{1'b1}}, {REG_DATA_WIDTH{1'b0}}};
            end
            if ((w_state_next == S_RSP) && (r_state != S_RSP)) begin
                r_rsp_data     <= w_rsp_data;
                r_rsp_err      <= w_rsp_err;
                r_rsp_reg_addr <= w_rsp_dst;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_reg_addr = r_rsp_reg_addr;
    assign rsp_data     = r_rsp_data;
    assign d_ncs        = r_d_ncs;
    assign d_nwe        = r_d_nwe;
    assign d_addr       = r_d_addr;
    assign d_wdata      = r_d_wdata;
    assign d_wmask      = r_d_wmask;

endmodule

// File: tb/tb_riscv32ima_amo_ctrl.sv
// Bench for riscv32ima_amo_ctrl: directed scenarios plus randomized atomics,
// checked against a word-level memory/reservation model.
module tb_riscv32ima_amo_ctrl;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MINU = 5'b11000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_func5 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [4:0]  req_dst_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [4:0]  rsp_reg_addr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        snp_valid = 1'b0;
    logic [31:0] snp_addr = '0;
    logic        d_ncs, d_nwe;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_wmask;
    logic [63:0] d_rdata = '0;
    logic        d_stall = 1'b1;

    always #5 clk = ~clk;

    riscv32ima_amo_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func5(req_func5),
        .req_addr(req_addr), .req_data(req_data), .req_dst_addr(req_dst_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_reg_addr(rsp_reg_addr),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .snp_valid(snp_valid), .snp_addr(snp_addr),
        .d_ncs(d_ncs), .d_nwe(d_nwe), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_stall(d_stall)
    );

    // memory: 256 words, responds to accepted accesses
    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    int          rd_cnt = 0, wr_cnt = 0;
    logic [31:0] last_waddr = '0;
    logic [63:0] last_wdata = '0, last_wmask = '0;

    always @(posedge clk) begin : mem_blk
        logic [7:0] wlo, whi;
        wlo = d_addr[9:2];
        whi = wlo | 8'd1;
        if (poke_en) mem[poke_idx] <= poke_val;
        if (!d_ncs && d_stall) begin
            if (d_nwe) begin
                d_rdata <= {mem[whi], mem[wlo]};
                rd_cnt  <= rd_cnt + 1;
            end else begin
                mem[wlo]   <= (mem[wlo] & d_wmask[31:0])  | (d_wdata[31:0]  & ~d_wmask[31:0]);
                mem[whi]   <= (mem[whi] & d_wmask[63:32]) | (d_wdata[63:32] & ~d_wmask[63:32]);
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= d_addr;
                last_wdata <= d_wdata;
                last_wmask <= d_wmask;
            end
        end
    end

    // stall generator and d_* stability monitor
    int   rd_hold_cfg = 0, wr_hold_cfg = 0;
    bit   rand_stall = 1'b0;
    int   rd_run = 0, wr_run = 0, ncs_cycles = 0, stab_err = 0;
    logic p_ncs = 1'b1, p_nwe = 1'b1;
    logic [31:0] p_addr = '0;
    logic [63:0] p_wdata = '0, p_wmask = '0;

    always @(negedge clk) begin
        if (!d_ncs) ncs_cycles++;
        if (!d_ncs && !p_ncs && d_nwe == p_nwe &&
            (d_addr !== p_addr || d_wdata !== p_wdata || d_wmask !== p_wmask)) stab_err++;
        p_ncs = d_ncs; p_nwe = d_nwe; p_addr = d_addr; p_wdata = d_wdata; p_wmask = d_wmask;
        if (!d_ncs && d_nwe) begin
            d_stall = (rd_run >= rd_hold_cfg) && (!rand_stall || $urandom_range(0, 2) != 0);
            rd_run++; wr_run = 0;
        end else if (!d_ncs) begin
            d_stall = (wr_run >= wr_hold_cfg) && (!rand_stall || $urandom_range(0, 2) != 0);
            wr_run++; rd_run = 0;
        end else begin
            rd_run = 0; wr_run = 0;
            d_stall = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // reference model state
    logic [31:0] ref_mem [0:255];
    bit          ref_rv = 1'b0;
    logic [31:0] ref_ra = '0;
    int          n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] amo_calc(input logic [4:0] f, input logic [31:0] o,
                                             input logic [31:0] s);
        int so, ss;
        so = $signed(o); ss = $signed(s);
        case (f)
            5'b00000: return o + s;
            5'b00100: return o ^ s;
            5'b01000: return o | s;
            5'b01100: return o & s;
            5'b10000: return (so <= ss) ? o : s;
            5'b10100: return (so >= ss) ? o : s;
            5'b11000: return (o <= s) ? o : s;
            5'b11100: return (o >= s) ? o : s;
            default:  return s;
        endcase
    endfunction

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] a);
        snp_valid = 1'b1; snp_addr = a;
        if (ref_rv && ref_ra[31:2] == a[31:2]) ref_rv = 1'b0;
        @(negedge clk);
        snp_valid = 1'b0;
    endtask

    // one atomic op; called right after a negedge; returns at a negedge
    task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [4:0] rd, input int hold, output int lat);
        logic [31:0] exp_data;
        bit          exp_err, quiet;
        int          exp_wr, w0, n0, k;
        logic [7:0]  idx;
        idx = a[9:2]; exp_err = 1'b0; exp_wr = 0; quiet = 1'b0; exp_data = '0;
        if (a[1:0] != 2'b00) begin
            exp_err = 1'b1; quiet = 1'b1;
        end else if (f == F_LR) begin
            exp_data = ref_mem[idx]; ref_rv = 1'b1; ref_ra = a;
        end else if (f == F_SC) begin
            if (ref_rv && ref_ra[31:2] == a[31:2]) begin
                ref_mem[idx] = rs2; exp_wr = 1;
            end else begin
                exp_data = 32'd1; quiet = 1'b1;
            end
            ref_rv = 1'b0;
        end else begin
            exp_data = ref_mem[idx];
            ref_mem[idx] = amo_calc(f, ref_mem[idx], rs2);
            exp_wr = 1;
        end
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) check("req_ready_timeout", req_ready, 1);
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_func5 = f; req_addr = a; req_data = rs2; req_dst_addr = rd;
        w0 = wr_cnt; n0 = ncs_cycles;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_func5 = 5'($urandom); req_data = $urandom;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_reg_addr", rsp_reg_addr, rd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_data", rsp_data, exp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_consumed", rsp_valid, 0);
        check("write_count", 64'(wr_cnt - w0), 64'(exp_wr));
        if (quiet) check("no_d_access", 64'(ncs_cycles - n0), 64'd0);
    endtask

    initial begin : main
        int lat, r0, w0, k;
        logic [4:0]  f;
        logic [31:0] a;
        logic [4:0]  amo_list [0:8];
        int bad;
        amo_list = '{5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
                     5'b10000, 5'b10100, 5'b11000, 5'b11100};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_d_ncs", d_ncs, 1);
        check("rst_d_nwe", d_nwe, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_d_addr", d_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_req_ready", req_ready, 1);

        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);

        // AMOADD.W at 0x104
        poke(8'h41, 32'h0000000A);
        r0 = rd_cnt;
        do_op(F_ADD, 32'h104, 32'd5, 5'd7, 0, lat);
        check("add_latency", lat, 4);
        check("add_reads", 64'(rd_cnt - r0), 64'd1);
        check("add_waddr", last_waddr, 32'h100);
        check("add_wdata", last_wdata, {32'h0F, 32'h0F});
        check("add_wmask", last_wmask, {32'h0, 32'hFFFFFFFF});

        // signed vs unsigned min
        poke(8'h44, 32'hFFFFFFFF);
        do_op(F_MIN, 32'h110, 32'd1, 5'd3, 0, lat);
        check("min_wdata", last_wdata, {32'hFFFFFFFF, 32'hFFFFFFFF});
        poke(8'h44, 32'hFFFFFFFF);
        do_op(F_MINU, 32'h110, 32'd1, 5'd4, 0, lat);
        check("minu_wdata", last_wdata, {32'h1, 32'h1});

        // LR / SC / second SC
        do_op(F_LR, 32'h200, 32'd0, 5'd10, 0, lat);
        check("lr_latency", lat, 3);
        do_op(F_SC, 32'h200, 32'h55, 5'd11, 0, lat);
        check("sc_latency", lat, 2);
        check("sc_wdata", last_wdata, {32'h55, 32'h55});
        check("sc_wmask", last_wmask, {32'hFFFFFFFF, 32'h0});
        do_op(F_SC, 32'h200, 32'h77, 5'd12, 0, lat);
        check("sc_fail_latency", lat, 1);

        // snoop kills the reservation
        do_op(F_LR, 32'h200, 32'd0, 5'd13, 0, lat);
        snoop(32'h203);
        do_op(F_SC, 32'h200, 32'h66, 5'd14, 0, lat);

        // stalls in RD and WR plus held response
        rd_hold_cfg = 3; wr_hold_cfg = 2;
        do_op(F_ADD, 32'h118, 32'd3, 5'd2, 3, lat);
        check("stall_latency", lat, 9);
        rd_hold_cfg = 0; wr_hold_cfg = 0;

        // misaligned op
        do_op(F_SWAP, 32'h102, 32'h1234, 5'd9, 0, lat);
        check("misaligned_latency", lat, 1);

        // reset asserted during WR
        do_op(F_LR, 32'h208, 32'd0, 5'd5, 0, lat);
        wr_hold_cfg = 50;
        w0 = wr_cnt;
        req_valid = 1'b1; req_func5 = F_ADD; req_addr = 32'h208; req_data = 32'd1; req_dst_addr = 5'd6;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (d_nwe !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("reached_wr", d_nwe, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr_hold_cfg = 0; ref_rv = 1'b0;
        check("rstwr_d_ncs", d_ncs, 1);
        check("rstwr_d_nwe", d_nwe, 1);
        check("rstwr_rsp_valid", rsp_valid, 0);
        check("rstwr_no_write", 64'(wr_cnt - w0), 64'd0);
        repeat (2) @(negedge clk);
        check("rstwr_req_ready", req_ready, 1);
        do_op(F_SC, 32'h208, 32'h99, 5'd8, 0, lat);

        // randomized traffic
        rand_stall = 1'b1;
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2)       f = F_LR;
            else if (k < 4)  f = F_SC;
            else if (k == 4) f = 5'($urandom);
            else             f = amo_list[$urandom_range(0, 8)];
            a = 32'h300 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 6) == 0) snoop(32'h300 + 32'($urandom_range(0, 31)));
            do_op(f, a, $urandom, 5'($urandom), $urandom_range(0, 2), lat);
        end
        rand_stall = 1'b0;

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("memory_image", 64'(bad), 64'd0);
        check("d_port_stable", 64'(stab_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
